// File: rtl/p_accumulator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : p_accumulator_if
// Brief    : Element-in / result-out handshake bundle for p_accumulator.
//            master = producer/consumer side, slave = accumulator side.
// Revision : 1.0 - initial release
// ============================================================================
interface p_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8
);
    logic                   op_valid;
    logic                   op_ready;
    logic [2*WIDTH-1:0]     product;
    logic [ACC_WIDTH-1:0]   acc_out;
    logic                   acc_sat;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output op_valid, product, out_ready,
        input  op_ready, acc_out, acc_sat, out_valid
    );

    modport slave (
        input  op_valid, product, out_ready,
        output op_ready, acc_out, acc_sat, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/p_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : p_accumulator
// Brief    : Dot-product accumulator behind a fixed-latency multiplier.
//            Accepted elements are tracked through a valid delay line that
//            lines up with the multiplier output; every DOT_LEN products the
//            sum is pushed into a 2-entry result FIFO.  Credit-based
//            op_ready keeps the FIFO from ever overflowing.
//            Optional feature macro: P_ACC_SAT_EN (saturating accumulation
//            with a per-vector sticky flag); undefined = modulo wrap.
// Revision : 1.0 - initial release
// ============================================================================
module p_accumulator #(
    parameter int WIDTH        = 8,
    parameter int ACC_WIDTH    = 2*WIDTH+8,
    parameter int DOT_LEN      = 16,
    parameter int MULT_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    p_accumulator_if.slave    bus
);

    // Valid must trail acceptance by the multiplier depth plus its input
    // and output registers so product is sampled exactly when it is ready.
    localparam int                  c_LAT      = MULT_LATENCY + 2;
    localparam int                  c_IDX_W    = $clog2(DOT_LEN);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(DOT_LEN - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE  = c_IDX_W'(1);

    logic [c_LAT-1:0]               vld_q;
    logic [c_IDX_W-1:0]             in_idx_q,  in_idx_d;
    logic [c_IDX_W-1:0]             acc_idx_q, acc_idx_d;
    logic [1:0]                     pending_q, pending_d;
    logic [ACC_WIDTH-1:0]           acc_q,     acc_d;
    logic                           sat_d;
`ifdef P_ACC_SAT_EN
    logic                           sat_q;
`endif

    logic [1:0][ACC_WIDTH-1:0]      fifo_data_q;
    logic [1:0]                     fifo_sat_q;
    logic                           wr_ptr_q, rd_ptr_q;
    logic [1:0]                     fifo_cnt_q, fifo_cnt_d;

    logic                           w_op_ready;
    logic                           w_accept;
    logic                           w_vec_start;
    logic                           w_dvalid;
    logic                           w_push;
    logic                           w_pop;
    logic [ACC_WIDTH-1:0]           w_prod_ext;
`ifdef P_ACC_SAT_EN
    logic [ACC_WIDTH:0]             w_sum;
`else
    logic [ACC_WIDTH-1:0]           w_sum;
`endif

    // A new vector may only start if both FIFO slots are not already
    // spoken for by stored results or vectors still in flight.
    assign w_op_ready  = (in_idx_q != '0) ||
                         ((3'(fifo_cnt_q) + 3'(pending_q)) < 3'd2);
    assign w_accept    = bus.op_valid && w_op_ready;
    assign w_vec_start = w_accept && (in_idx_q == '0);
    assign w_dvalid    = vld_q[c_LAT-1];
    assign w_push      = w_dvalid && (acc_idx_q == c_IDX_LAST);
    assign w_pop       = (fifo_cnt_q != 2'd0) && bus.out_ready;
    assign w_prod_ext  = ACC_WIDTH'(bus.product);

`ifdef P_ACC_SAT_EN
    assign w_sum = {1'b0, acc_q} + {1'b0, w_prod_ext};
`else
    assign w_sum = acc_q + w_prod_ext;
`endif

    assign bus.op_ready  = w_op_ready;
    assign bus.out_valid = (fifo_cnt_q != 2'd0);
    assign bus.acc_out   = fifo_data_q[rd_ptr_q];
    assign bus.acc_sat   = fifo_sat_q[rd_ptr_q];

    // Input/output element indices, in-flight vector credit and FIFO fill.
    always_comb begin
        in_idx_d   = in_idx_q;
        acc_idx_d  = acc_idx_q;
        pending_d  = pending_q;
        fifo_cnt_d = fifo_cnt_q;

        if (w_accept) begin
            in_idx_d = (in_idx_q == c_IDX_LAST) ? '0 : in_idx_q + c_IDX_ONE;
        end

        if (w_dvalid) begin
            acc_idx_d = (acc_idx_q == c_IDX_LAST) ? '0 : acc_idx_q + c_IDX_ONE;
        end

        case ({w_vec_start, w_push})
            2'b10:   pending_d = pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase

        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Accumulator datapath: first product of a vector loads, the rest add.
    always_comb begin
        acc_d = acc_q;
`ifdef P_ACC_SAT_EN
        sat_d = sat_q;
`else
        sat_d = 1'b0;
`endif
        if (w_dvalid) begin
            if (acc_idx_q == '0) begin
                acc_d = w_prod_ext;
                sat_d = 1'b0;
            end else begin
`ifdef P_ACC_SAT_EN
                if (w_sum[ACC_WIDTH]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = w_sum[ACC_WIDTH-1:0];
                end
`else
                acc_d = w_sum[ACC_WIDTH-1:0];
`endif
            end
        end
    end

    // State registers; reset drops any partial vector and in-flight valids.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q       <= '0;
            in_idx_q    <= '0;
            acc_idx_q   <= '0;
            pending_q   <= 2'd0;
            acc_q       <= '0;
`ifdef P_ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
            fifo_data_q <= '0;
            fifo_sat_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            vld_q      <= {vld_q[c_LAT-2:0], w_accept};
            in_idx_q   <= in_idx_d;
            acc_idx_q  <= acc_idx_d;
            pending_q  <= pending_d;
            acc_q      <= acc_d;
`ifdef P_ACC_SAT_EN
            sat_q      <= sat_d;
`endif
            fifo_cnt_q <= fifo_cnt_d;
            if (w_push) begin
                fifo_data_q[wr_ptr_q] <= acc_d;
                fifo_sat_q[wr_ptr_q]  <= sat_d;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // The credit rule must never let a result land on a full FIFO.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (reset) !(w_push && (fifo_cnt_q == 2'd2))
    );

endmodule
`default_nettype wire
